// File: rtl/seg_scan.sv
// Four-digit common-anode seven-segment scan driver: advances one digit per rising
// edge of hz_fst and drives registered, active-low segment/anode pins with blank/dp/blink.
module seg_scan #(
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_fst,
    input  logic [15:0] digits,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp,
    input  logic [3:0]  blink,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an
);

    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_TICKS - 1);

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_pattern(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    logic             hz_q;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic             tick;
    logic             dark;
    logic [3:0]       nibble;

    always_comb begin
        tick          = hz_fst & ~hz_q;
        sel_d         = sel_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick) begin
            sel_d = sel_q + 2'd1;
            if (blink_cnt_q == CNT_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        case (sel_q)
            2'd0:    nibble = digits[3:0];
            2'd1:    nibble = digits[7:4];
            2'd2:    nibble = digits[11:8];
            default: nibble = digits[15:12];
        endcase

        // Outputs use the pre-increment sel, so an and seg always switch together.
        dark   = blank[sel_q] | (blink[sel_q] & blink_phase_q);
        an_d   = dark ? 4'hF  : ~(4'b0001 << sel_q);
        seg_d  = dark ? 7'h7F : ~hex_pattern(nibble);
        dp_n_d = dark ? 1'b1  : ~dp[sel_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hz_q          <= 1'b0;
            sel_q         <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_n_q        <= 1'b1;
        end else begin
            hz_q          <= hz_fst;
            sel_q         <= sel_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp_n = dp_n_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with a short blink period.
module tb_seg_scan;

    logic        clk;
    logic        rst;
    logic        hz_fst;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;

    int n_checks = 0;
    int n_pass   = 0;

    seg_scan #(.BLINK_TICKS(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .hz_fst (hz_fst),
        .digits (digits),
        .blank  (blank),
        .dp     (dp),
        .blink  (blink),
        .seg    (seg),
        .dp_n   (dp_n),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] val;
        logic [6:0] seg;
    } dec_vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } scan_vec_t;

    dec_vec_t  dec_tab[16];
    scan_vec_t scan_tab[4];

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One full hz_fst period of 8 clk: exactly one rising edge.
    task automatic pulse();
        hz_fst = 1'b1;
        step(4);
        hz_fst = 1'b0;
        step(4);
    endtask

    initial begin
        dec_tab[0]  = '{4'h0, 7'h40};  dec_tab[1]  = '{4'h1, 7'h79};
        dec_tab[2]  = '{4'h2, 7'h24};  dec_tab[3]  = '{4'h3, 7'h30};
        dec_tab[4]  = '{4'h4, 7'h19};  dec_tab[5]  = '{4'h5, 7'h12};
        dec_tab[6]  = '{4'h6, 7'h02};  dec_tab[7]  = '{4'h7, 7'h78};
        dec_tab[8]  = '{4'h8, 7'h00};  dec_tab[9]  = '{4'h9, 7'h10};
        dec_tab[10] = '{4'hA, 7'h08};  dec_tab[11] = '{4'hB, 7'h03};
        dec_tab[12] = '{4'hC, 7'h46};  dec_tab[13] = '{4'hD, 7'h21};
        dec_tab[14] = '{4'hE, 7'h06};  dec_tab[15] = '{4'hF, 7'h0E};

        scan_tab[0] = '{4'b1101, 7'h30};
        scan_tab[1] = '{4'b1011, 7'h24};
        scan_tab[2] = '{4'b0111, 7'h79};
        scan_tab[3] = '{4'b1110, 7'h19};

        rst    = 1'b1;
        hz_fst = 1'b0;
        digits = 16'h1234;
        blank  = 4'h0;
        dp     = 4'h0;
        blink  = 4'h0;

        // Reset and first display
        step(3);
        check("reset_an",   16'(an),   16'hF);
        check("reset_seg",  16'(seg),  16'h7F);
        check("reset_dp_n", 16'(dp_n), 16'h1);
        rst = 1'b0;
        step();
        check("first_an",  16'(an),  16'hE);
        check("first_seg", 16'(seg), 16'h19);

        // Scan order over four hz_fst periods
        for (int k = 0; k < 4; k++) begin
            pulse();
            check($sformatf("scan%0d_an", k),  16'(an),  16'(scan_tab[k].an));
            check($sformatf("scan%0d_seg", k), 16'(seg), 16'(scan_tab[k].seg));
        end

        // Decode sweep on digit0 (hz_fst idle, sel stays 0)
        for (int i = 0; i < 16; i++) begin
            digits = {12'h123, dec_tab[i].val};
            step();
            check($sformatf("dec_%h", dec_tab[i].val), 16'(seg), 16'(dec_tab[i].seg));
        end
        digits = 16'h1234;

        // Decimal point and blank
        dp    = 4'b0001;
        blank = 4'b0010;
        step();
        check("dp0_dp_n", 16'(dp_n), 16'h0);
        check("dp0_an",   16'(an),   16'hE);
        pulse();
        check("blank1_an",   16'(an),   16'hF);
        check("blank1_seg",  16'(seg),  16'h7F);
        check("blank1_dp_n", 16'(dp_n), 16'h1);
        pulse();
        check("blank2_an",   16'(an),   16'hB);
        check("blank2_seg",  16'(seg),  16'h24);
        check("blank2_dp_n", 16'(dp_n), 16'h1);
        pulse();
        check("blank3_an",  16'(an),  16'h7);
        pulse();
        check("blank0_an",   16'(an),   16'hE);
        check("blank0_dp_n", 16'(dp_n), 16'h0);
        dp    = 4'h0;
        blank = 4'h0;

        // Tick and input change in the same cycle: old sel, new value first
        hz_fst = 1'b1;
        digits = 16'h1235;
        step();
        check("same_cyc_an",  16'(an),  16'hE);
        check("same_cyc_seg", 16'(seg), 16'h12);
        step();
        check("next_cyc_an",  16'(an),  16'hD);
        check("next_cyc_seg", 16'(seg), 16'h30);
        step(2);
        hz_fst = 1'b0;
        step(4);
        repeat (3) pulse();
        check("realign_an", 16'(an), 16'hE);

        // Blink: phase is 1 while sel is 2 or 3 (2 ticks per half-period)
        blink = 4'b0101;
        step();
        check("blk_a0", 16'(an), 16'hE);
        pulse();
        check("blk_a1", 16'(an), 16'hD);
        pulse();
        check("blk_a2_an",  16'(an),  16'hF);
        check("blk_a2_seg", 16'(seg), 16'h7F);
        pulse();
        check("blk_a3", 16'(an), 16'h7);
        pulse();
        check("blk_a0b", 16'(an), 16'hE);
        blink = 4'b1111;
        pulse();
        check("blk_b1", 16'(an), 16'hD);
        pulse();
        check("blk_b2", 16'(an), 16'hF);
        pulse();
        check("blk_b3", 16'(an), 16'hF);
        pulse();
        check("blk_b0", 16'(an), 16'hE);
        blink = 4'h0;

        // Long high level gives exactly one advance
        hz_fst = 1'b1;
        step(100);
        check("hold_hi_an", 16'(an), 16'hD);
        hz_fst = 1'b0;
        step(100);
        check("hold_lo_an", 16'(an), 16'hD);

        // Reset mid-scan at sel=2 with blink phase 1
        pulse();
        check("pre_rst_an", 16'(an), 16'hB);
        blink = 4'b0001;
        rst   = 1'b1;
        step();
        check("mid_rst_an",   16'(an),   16'hF);
        check("mid_rst_seg",  16'(seg),  16'h7F);
        check("mid_rst_dp_n", 16'(dp_n), 16'h1);
        rst = 1'b0;
        step();
        check("post_rst_an",  16'(an),  16'hE);
        check("post_rst_seg", 16'(seg), 16'h12);
        blink = 4'b0100;
        pulse();
        pulse();
        check("post_rst_blk2", 16'(an), 16'hF);
        blink = 4'h0;
        step();
        check("post_rst_sel2", 16'(an), 16'hB);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
